// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, one bit per cycle, LSB first.
// Optional signed overflow flag enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bout,
  output logic         zero,
  output logic         ovf
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [W-1:0]  r_sr;
  logic [W-1:0]  res;
  logic [CW-1:0] cnt;
  logic          br;
  logic          br_nx;
  logic          x;
  logic          y;
  logic          dbit;
  logic          accept;
  logic          last;
  logic          fin;

  assign accept = start && (state != RUN);
  assign last   = (cnt == LAST);
  assign fin    = (state == RUN) && last;

  assign x     = a_sr[0];
  assign y     = b_sr[0];
  assign dbit  = x ^ y ^ br;
  assign br_nx = (~x & y) | (~(x ^ y) & br);
  assign res   = {dbit, r_sr[W-1:1]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      r_sr <= '0;
      cnt  <= '0;
      br   <= bin;
    end else if (state == RUN) begin
      a_sr <= {1'b0, a_sr[W-1:1]};
      b_sr <= {1'b0, b_sr[W-1:1]};
      r_sr <= res;
      br   <= br_nx;
      cnt  <= cnt + CW'(1);
      // Visible outputs move only on the completing edge
      if (last) begin
        d    <= res;
        bout <= br_nx;
        zero <= (res == '0);
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic am;
  logic bm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am  <= 1'b0;
      bm  <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      am <= a[W-1];
      bm <= b[W-1];
    end else if (fin) begin
      ovf <= (am ^ bm) & (res[W-1] ^ am);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at W=4.
// Expected values are hand-computed constants.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [3:0] d;
  logic       bout;
  logic       zero;
  logic       ovf;

  int n_chk;
  int n_fail;

`ifdef SERIAL_SUB_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  serial_subtractor #(.W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout),
    .zero (zero),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one accept; returns at the first negedge after the accepting edge
  task automatic start_op(input logic [3:0] av,
                          input logic [3:0] bv,
                          input logic       bi);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    bin   = bi;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int k0, output int k, output int nb);
    k  = k0;
    nb = 0;
    while (!done && k < 20) begin
      if (busy) nb++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_res(input string tag,
                           input logic [3:0] ed,
                           input logic eb,
                           input logic ez,
                           input logic eo);
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, ".d"}, {28'd0, d}, {28'd0, ed});
    check({tag, ".bout"}, {31'd0, bout}, {31'd0, eb});
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo & OVF_EN});
  endtask

  task automatic full_op(input string tag,
                         input logic [3:0] av,
                         input logic [3:0] bv,
                         input logic bi,
                         input logic [3:0] ed,
                         input logic eb,
                         input logic ez,
                         input logic eo);
    int k;
    int nb;
    start_op(av, bv, bi);
    wait_done(0, k, nb);
    check({tag, ".lat"}, k, 4);
    check({tag, ".nbusy"}, nb, 4);
    check_res(tag, ed, eb, ez, eo);
    @(negedge clk);
    check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int k;
    int nb;
    int seen;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;
    #12;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.d", {28'd0, d}, 32'd0);
    check("rst.flags", {29'd0, bout, zero, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    full_op("9m3", 4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b0, 1'b1);
    full_op("3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1);
    full_op("5m5b", 4'd5, 4'd5, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    full_op("7m7", 4'd7, 4'd7, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    full_op("1m0", 4'd1, 4'd0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
    full_op("8m1", 4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1);

    // start during RUN is ignored; outputs hold previous result
    start_op(4'd2, 4'd1, 1'b0);
    @(negedge clk);
    check("ign.hold_d", {28'd0, d}, 32'h7);
    @(negedge clk);
    start = 1'b1;
    a     = 4'hF;
    b     = 4'h0;
    bin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, k, nb);
    check("ign.lat", k, 4);
    check_res("ign", 4'h1, 1'b0, 1'b0, 1'b0);

    // back-to-back: start in DONE cycle
    @(negedge clk);
    start_op(4'd6, 4'd2, 1'b0);
    wait_done(0, k, nb);
    check_res("b2b1", 4'h4, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    a     = 4'hC;
    b     = 4'h5;
    bin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, k, nb);
    check("b2b2.lat", k, 4);
    check_res("b2b2", 4'h7, 1'b0, 1'b0, 1'b1);

    // reset mid-RUN
    @(negedge clk);
    start_op(4'd9, 4'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst.busy", {31'd0, busy}, 32'd0);
    check("mrst.d", {28'd0, d}, 32'd0);
    check("mrst.flags", {29'd0, bout, zero, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("mrst.no_done", seen, 0);
    full_op("post", 4'd4, 4'd1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
